// File: rtl/rlc_pkg.sv
// Shared definitions for the RLC block encoder/decoder pair: widths, word layout, FSM states, zigzag LUT.
package rlc_pkg;

  localparam int unsigned N       = 10;
  localparam int unsigned CW      = N + 1;
  localparam int unsigned AW      = 11;
  localparam int unsigned DW      = 99;
  localparam int unsigned ENTRIES = 8;
  localparam int unsigned NCOEF   = 64;
  localparam int unsigned POS_W   = 7;

  localparam int unsigned DC_LSB  = 88;
  localparam int unsigned R_LSB   = 64;
  localparam int unsigned L_LSB   = 32;
  localparam int unsigned F_LSB   = 0;
  localparam int unsigned RUN_W   = 3;
  localparam int unsigned LVL_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_DECODE,
    S_EMIT,
    S_DONE
  } state_e;

  // Entry fields of one SRAM word, kept for the decode pass.
  typedef struct packed {
    logic [ENTRIES*RUN_W-1:0] run;
    logic [ENTRIES*LVL_W-1:0] lvl;
    logic [ENTRIES-1:0]       flag;
  } rlc_entries_t;

  // JPEG zigzag scan: zigzag position -> raster index (row*8+col).
  localparam logic [5:0] ZZ_LUT [NCOEF] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [5:0] zz_to_raster(input logic [5:0] zz_pos);
    return ZZ_LUT[zz_pos];
  endfunction

endpackage

// File: rtl/rlc_zigzag_rom.sv
// Combinational zigzag position -> raster index lookup.
module rlc_zigzag_rom
  import rlc_pkg::*;
(
  input  logic [5:0] zz_pos,
  output logic [5:0] raster_idx_c
);

  // Table lookup shared with the encoder through the package.
  always_comb begin
    raster_idx_c = zz_to_raster(zz_pos);
  end

endmodule

// File: rtl/rlc_decoder.sv
// Reads RLC-packed words from SRAM, rebuilds each 8x8 block and streams it out in raster order.
module rlc_decoder
  import rlc_pkg::*;
(
  input  logic          clk,
  input  logic          srst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] num_blocks,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] sram_raddr,
  output logic          sram_ren,
  input  logic [DW-1:0] sram_rdata,
  output logic          coef_valid,
  input  logic          coef_ready,
  output logic [N:0]    coef_data,
  output logic [5:0]    coef_idx,
  output logic          blk_last
);

  state_e             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [AW-1:0]      remain_q, remain_d;
  logic [AW-1:0]      raddr_q, raddr_d;
  logic [2:0]         k_q, k_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               stop_q, stop_d;
  rlc_entries_t       word_q, word_d;
  logic [CW-1:0]      coef_buf_q [NCOEF];
  logic [CW-1:0]      coef_buf_d [NCOEF];
  logic [5:0]         idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ren_q, ren_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [CW-1:0]      data_q, data_d;

  logic [RUN_W-1:0]   run_k;
  logic [LVL_W-1:0]   lvl_k;
  logic               flag_k;
  logic [POS_W-1:0]   p_sum;
  logic [5:0]         wr_raster_c;
  logic               unused_rdata;

  // Upper flag bits carry no entries.
  assign unused_rdata = ^sram_rdata[F_LSB+ENTRIES +: 32-ENTRIES];

  rlc_zigzag_rom u_zz (
    .zz_pos       (p_sum[5:0]),
    .raster_idx_c (wr_raster_c)
  );

  // Next-state, datapath and next-output computation.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    k_d        = k_q;
    pos_d      = pos_q;
    stop_d     = stop_q;
    word_d     = word_q;
    coef_buf_d = coef_buf_q;
    idx_d      = idx_q;
    err_d      = err_q;
    done_d     = 1'b0;

    run_k  = word_q.run[32'(k_q)*RUN_W +: RUN_W];
    lvl_k  = word_q.lvl[32'(k_q)*LVL_W +: LVL_W];
    flag_k = word_q.flag[k_q];
    p_sum  = pos_q + POS_W'(run_k);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = num_blocks;
          err_d    = 1'b0;
          // Empty job: nothing to read, finish right away.
          if (num_blocks == '0) done_d = 1'b1;
          else                  state_d = S_READ;
        end
      end
      S_READ: begin
        coef_buf_d = '{default: '0};
        idx_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        word_d.run    = sram_rdata[R_LSB +: ENTRIES*RUN_W];
        word_d.lvl    = sram_rdata[L_LSB +: ENTRIES*LVL_W];
        word_d.flag   = sram_rdata[F_LSB +: ENTRIES];
        coef_buf_d[0] = sram_rdata[DC_LSB +: CW];
        pos_d         = POS_W'(1);
        stop_d        = 1'b0;
        k_d           = '0;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        if (!stop_q && flag_k) begin
          if (p_sum <= POS_W'(NCOEF-1)) begin
            coef_buf_d[wr_raster_c] = {{(CW-LVL_W){lvl_k[LVL_W-1]}}, lvl_k};
            pos_d                   = p_sum + POS_W'(1);
          end else begin
            err_d  = 1'b1;
            stop_d = 1'b1;
          end
        end else begin
          stop_d = 1'b1;
        end
        k_d = k_q + 3'd1;
        if (k_q == 3'(ENTRIES-1)) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (valid_q && coef_ready) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'(NCOEF-1)) begin
            remain_d = remain_q - AW'(1);
            addr_d   = addr_q + AW'(1);
            state_d  = (remain_q == AW'(1)) ? S_DONE : S_READ;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    ren_d   = (state_d == S_READ);
    raddr_d = (state_d == S_READ) ? addr_d : raddr_q;
    valid_d = (state_d == S_EMIT);
    data_d  = valid_d ? coef_buf_d[idx_d] : '0;
    last_d  = valid_d && (idx_d == 6'(NCOEF-1));
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      raddr_q    <= '0;
      k_q        <= '0;
      pos_q      <= '0;
      stop_q     <= 1'b0;
      word_q     <= '0;
      coef_buf_q <= '{default: '0};
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ren_q      <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      raddr_q    <= raddr_d;
      k_q        <= k_d;
      pos_q      <= pos_d;
      stop_q     <= stop_d;
      word_q     <= word_d;
      coef_buf_q <= coef_buf_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ren_q      <= ren_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      data_q     <= data_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign sram_raddr = raddr_q;
  assign sram_ren   = ren_q;
  assign coef_valid = valid_q;
  assign coef_data  = data_q;
  assign coef_idx   = idx_q;
  assign blk_last   = last_q;

endmodule
